// File: rtl/flag_ctrl.sv
// NVZ flag register and ID-stage branch resolution. Tracks which flags the
// instruction in EX will write and stalls a dependent branch for one cycle.
module flag_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [2:0]       id_ccc,
  input  logic             flush,
  input  logic             hold,
  input  logic [2:0]       alu_flags,
  output logic             N_flag,
  output logic             V_flag,
  output logic             Z_flag,
  output logic             br_stall,
  output logic             br_taken,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;

  // Bit order everywhere is {N,V,Z}.
  logic [2:0]       id_mask;
  logic [2:0]       ex_mask_reg;
  logic [2:0]       flags_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             id_live;
  logic             is_br;
  logic             cond;

  assign id_live = id_valid & ~flush;

  always_comb begin
    id_mask = 3'b000;
    if (id_live) begin
      case (id_opcode)
        OP_ADD, OP_SUB:                 id_mask = 3'b111;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: id_mask = 3'b001;
        default:                        id_mask = 3'b000;
      endcase
    end
  end

  assign is_br = id_live & ((id_opcode == OP_B) | (id_opcode == OP_BR));

  // Condition sees committed flags only; a dependent branch stalls instead.
  always_comb begin
    cond = 1'b0;
    case (id_ccc)
      3'b000:  cond = ~flags_reg[0];
      3'b001:  cond = flags_reg[0];
      3'b010:  cond = ~flags_reg[0] & ~flags_reg[2];
      3'b011:  cond = flags_reg[2];
      3'b100:  cond = flags_reg[0] | ~flags_reg[2];
      3'b101:  cond = flags_reg[2] | flags_reg[0];
      3'b110:  cond = flags_reg[1];
      default: cond = 1'b1;
    endcase
  end

  assign br_stall = is_br & (ex_mask_reg != 3'b000);
  assign br_taken = is_br & ~br_stall & cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mask_reg <= 3'b000;
    end else if (!hold) begin
      ex_mask_reg <= br_stall ? 3'b000 : id_mask;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_flag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          flags_reg[gi] <= 1'b0;
        end else if (!hold && ex_mask_reg[gi]) begin
          flags_reg[gi] <= alu_flags[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (!hold && br_stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign N_flag    = flags_reg[2];
  assign V_flag    = flags_reg[1];
  assign Z_flag    = flags_reg[0];
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_flag_ctrl.sv
// Scoreboard bench for flag_ctrl: a directed prologue followed by random
// traffic, checked against an instruction-level model of the flag pipeline.
module tb_flag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [3:0]  id_opcode = 4'h0;
  logic [2:0]  id_ccc = 3'b000;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  alu_flags = 3'b000;
  logic        n16, v16, z16, stall16, taken16;
  logic        n4, v4, z4, stall4, taken4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  flag_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ccc(id_ccc), .flush(flush), .hold(hold), .alu_flags(alu_flags),
    .N_flag(n16), .V_flag(v16), .Z_flag(z16),
    .br_stall(stall16), .br_taken(taken16), .stall_cnt(cnt16)
  );

  flag_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ccc(id_ccc), .flush(flush), .hold(hold), .alu_flags(alu_flags),
    .N_flag(n4), .V_flag(v4), .Z_flag(z4),
    .br_stall(stall4), .br_taken(taken4), .stall_cnt(cnt4)
  );

  typedef struct {
    int         idx;
    logic [2:0] nvz;
    logic       stall;
    logic       taken;
    int         cnt16;
    int         cnt4;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Reference model state: committed flags, the instruction sitting in EX
  // (-1 for none/bubble), and an unbounded count of stall cycles.
  bit m_n, m_v, m_z;
  int m_ex_op = -1;
  int m_stalls = 0;

  // Flags an opcode writes, as {N,V,Z}.
  function automatic logic [2:0] writes(input int op);
    if (op == 0 || op == 1) return 3'b111;
    if (op == 2 || op == 4 || op == 5 || op == 6) return 3'b001;
    return 3'b000;
  endfunction

  function automatic bit branch_cond(input int ccc, input bit n, input bit v, input bit z);
    case (ccc)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step(input bit r, input bit v, input int op, input int ccc,
                      input bit f, input bit h, input logic [2:0] alu);
    exp_t e;
    bit   live, is_br, stall;
    logic [2:0] w;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_opcode = op[3:0]; id_ccc = ccc[2:0];
    flush = f; hold = h; alu_flags = alu;
    if (r) begin
      m_n = 0; m_v = 0; m_z = 0; m_ex_op = -1; m_stalls = 0;
    end
    #1;
    live  = v && !f;
    is_br = live && (op == 12 || op == 13);
    stall = is_br && (writes(m_ex_op) != 3'b000);
    e.idx   = txn;
    e.nvz   = {m_n, m_v, m_z};
    e.stall = stall;
    e.taken = is_br && !stall && branch_cond(ccc, m_n, m_v, m_z);
    e.cnt16 = (m_stalls > 65535) ? 65535 : m_stalls;
    e.cnt4  = (m_stalls > 15) ? 15 : m_stalls;
    sb_q.push_back(e);
    txn++;
    if (!r && !h) begin
      w = writes(m_ex_op);
      if (w[2]) m_n = alu[2];
      if (w[1]) m_v = alu[1];
      if (w[0]) m_z = alu[0];
      if (stall) m_stalls++;
      m_ex_op = (stall || !live) ? -1 : op;
    end
  endtask

  task automatic chk(input int idx, input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL txn=%0d %s actual=%0d required=%0d", idx, name, act, req);
    end
  endtask

  // Monitor: outputs are combinationally valid every cycle, so one
  // expectation is consumed per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.idx, "nvz",      int'({n16, v16, z16}), int'(e.nvz));
        chk(e.idx, "br_stall", int'(stall16), int'(e.stall));
        chk(e.idx, "br_taken", int'(taken16), int'(e.taken));
        chk(e.idx, "stall_cnt16", int'(cnt16), e.cnt16);
        chk(e.idx, "stall_cnt4",  int'(cnt4), e.cnt4);
        chk(e.idx, "nvz4",     int'({n4, v4, z4}), int'(e.nvz));
        $display("txn %0d rst=%b op=%h ccc=%0d fl=%b hold=%b nvz=%b stall=%b taken=%b cnt=%0d/%0d",
                 e.idx, rst, id_opcode, id_ccc, flush, hold, {n16, v16, z16},
                 stall16, taken16, cnt16, cnt4);
      end
    end
  end

  initial begin
    // Reset and mid-operation reset while ex_mask=111.
    step(1, 0, 15, 0, 0, 0, 3'b000);
    step(0, 1, 0, 0, 0, 0, 3'b000);   // ADD in ID
    step(1, 1, 15, 0, 0, 0, 3'b111);  // reset while ADD in EX
    step(0, 1, 12, 1, 0, 0, 3'b111);  // B EQ after reset: not taken
    // SUB -> Z=1, then dependent B EQ stalls once and then resolves taken.
    step(0, 1, 1, 0, 0, 0, 3'b000);
    step(0, 1, 12, 1, 0, 0, 3'b001);
    step(0, 1, 12, 1, 0, 0, 3'b000);
    // ADD N,V; NOP; B OVFL taken; B GT not taken.
    step(0, 1, 0, 0, 0, 0, 3'b000);
    step(0, 1, 15, 0, 0, 0, 3'b110);
    step(0, 1, 12, 6, 0, 0, 3'b000);
    step(0, 1, 13, 2, 0, 0, 3'b000);
    // XOR partial write keeps N,V; LW changes nothing.
    step(0, 1, 2, 0, 0, 0, 3'b000);
    step(0, 1, 8, 0, 0, 0, 3'b001);
    step(0, 1, 15, 0, 0, 0, 3'b000);
    // SUB in EX, B in ID frozen by hold for 3 cycles.
    step(0, 1, 1, 0, 0, 0, 3'b000);
    step(0, 1, 12, 0, 0, 1, 3'b100);
    step(0, 1, 12, 0, 0, 1, 3'b100);
    step(0, 1, 12, 0, 0, 1, 3'b100);
    step(0, 1, 12, 0, 0, 0, 3'b100);
    step(0, 1, 12, 0, 0, 0, 3'b000);
    // Flushed branch behind ADD: no stall, bubble recorded.
    step(0, 1, 0, 0, 0, 0, 3'b000);
    step(0, 1, 12, 7, 1, 0, 3'b011);
    step(0, 1, 12, 7, 0, 0, 3'b000);
    // Back-to-back setter/branch pairs to saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 0, 0, 0, 3'b000);
      step(0, 1, 12, 3, 0, 0, 3'($urandom_range(0, 7)));
      step(0, 1, 12, 3, 0, 0, 3'b000);
    end
    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      int  sel, op;
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? $urandom_range(0, 1) :
            (sel < 7) ? (12 + $urandom_range(0, 1)) : $urandom_range(0, 15);
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0), op,
           $urandom_range(0, 7), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 6) == 0), 3'($urandom_range(0, 7)));
    end
    repeat (3) @(posedge clk);
    chk(-1, "scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
